cache_refill_axi: RTL and testbench
===================================

// Module: cache_refill_axi
// PURPOSE
//  AXI4 read master that refills one cache line on a miss. Sits directly upstream of the
//  cache's memory-side port. Captures the missing line address, issues one INCR read burst
//  for the whole line, then streams the returned beats into mem_addr/mem_data_in/mem_wstb,
//  with mem_data_valid and mem_last.
// PARAMETERS
//  ADDR_WIDTH      32  address width; matches the cache
//  DATA_WIDTH      32  AXI RDATA width and cache word width; 32 or 64
//  LINE_SIZE_BITS  7   log2 of line bytes; matches the cache
//  Derived: BPW=DATA_WIDTH/8; BEATS=2^LINE_SIZE_BITS/BPW; BEATS must be 2..256
// PORTS
//  clk             in   1      clock; all logic rises on posedge
//  reset           in   1      synchronous, active-high reset
//  cpu_addr        in   AW     CPU address; sampled when a miss starts
//  miss            in   1      cache miss flag; high while the cache waits for a refill
//  mem_addr        out  AW     byte address of the current beat
//  mem_data_in     out  DW     beat data; cache side
//  mem_wstb        out  DW/8   byte strobes; all ones on every valid beat
//  mem_data_valid  out  1      beat valid; one-cycle pulse per beat
//  mem_last        out  1      final beat of the line; only with mem_data_valid
//  m_axi_araddr    out  AW     line-aligned burst address
//  m_axi_arlen     out  8      fixed at BEATS-1
//  m_axi_arsize    out  3      fixed at log2(BPW)
//  m_axi_arburst   out  2      fixed at 2'b01 (INCR)
//  m_axi_arvalid   out  1      AR valid
//  m_axi_arready   in   1      AR ready
//  m_axi_rdata     in   DW     R data
//  m_axi_rresp     in   2      R response
//  m_axi_rlast     in   1      R last
//  m_axi_rvalid    in   1      R valid
//  m_axi_rready    out  1      R ready; high only in DATA state
//  busy            out  1      high in any state except IDLE
//  refill_err      out  1      sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except the fixed AR fields; beat counter 0; refill_err 0.
//   Reset mid-burst abandons the transaction immediately; interconnect is reset alongside.
//  FSM IDLE -> ADDR -> DATA -> WAIT_CLR -> IDLE
//  IDLE: on miss=1:
//   - base <= {cpu_addr[AW-1:LINE_SIZE_BITS], 0}
//   - araddr <= base; arvalid <= 1; next state ADDR
//  ADDR: hold arvalid and araddr stable until arready. On the handshake: arvalid <= 0;
//   rready <= 1; next state DATA.
//  DATA: each rvalid&rready handshake at beat count n, registered for the next cycle:
//   - mem_addr = base + n*BPW
//   - mem_data_in = rdata; mem_wstb = all ones; mem_data_valid = 1
//   - mem_last = (n==BEATS-1)
//   The cache sees each beat one cycle after its AXI handshake. No beat is dropped.
//   Missing handshake cycles drive mem_data_valid=0; the other mem outputs hold.
//   After beat BEATS-1: rready <= 0; next state WAIT_CLR.
//  Errors; all beats still forwarded and the refill completes:
//   - rlast != (n==BEATS-1): refill_err <= 1
//   - rresp != 2'b00: refill_err <= 1
//  Termination: the beat counter alone decides termination; an early rlast does not end the refill.
//  WAIT_CLR: stay until miss=0, then IDLE. This blocks re-triggering on the miss cycle that
//   overlaps mem_last. A new miss is accepted no earlier than the cycle after miss is seen low.
//  Outstanding bursts: exactly one; AR is never issued during DATA or WAIT_CLR.
//  Beat counter: log2(BEATS)+1 bits; no wrap within a burst.
//  mem_addr: line offset bits increment; upper bits stay equal to base.
// TESTING
//  1 Reset: reset=1 for 2 cycles -> arvalid=0, rready=0, mem_data_valid=0, busy=0, refill_err=0.
//  2 Basic refill, defaults:
//    - stimulus: miss=1, cpu_addr=0x0000_1234; arready same cycle
//    - AR: araddr=0x0000_1200, arlen=31, arsize=2, arburst=1
//    - 32 back-to-back beats -> mem_addr 0x1200..0x127C step 4
//    - mem_last only on 0x127C; busy drops after miss=0
//  3 AR backpressure: arready low for 5 cycles -> arvalid and araddr held stable; rready stays 0.
//  4 R gaps: rvalid toggles 1,0,0,1,... -> mem_data_valid matches each handshake one cycle
//    later; data order preserved; beat count exact.
//  5 Errors, each -> refill_err=1, all 32 beats still delivered, mem_last on beat 31:
//    - rresp=2'b10 on beat 7
//    - rlast on beat 30
//  6 Reset asserted during beat 10 -> next cycle IDLE, outputs 0; a fresh miss then completes cleanly.

Source files
------------

// File: rtl/cache_refill_axi.sv
// Cache line refill master: one AXI4 INCR read burst per miss, beats forwarded to the cache one cycle after each R handshake.
// R is never stalled mid-burst except by the slave; AR is held until arready and only one burst is ever outstanding.
module cache_refill_axi #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_SIZE_BITS = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic                    miss,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic [DATA_WIDTH/8-1:0] mem_wstb,
  output logic                    mem_data_valid,
  output logic                    mem_last,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    busy,
  output logic                    refill_err
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int BEATS = (1 << LINE_SIZE_BITS) / BPW;
  localparam int SZ    = $clog2(BPW);
  localparam int CW    = $clog2(BEATS) + 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ADDR     = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_WAIT_CLR = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CW-1:0]         beat_cnt;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  last_beat;
  logic                  r_hs;
  logic                  beat_err;
  logic                  unused_offset_bits;

  assign line_base = {cpu_addr[ADDR_WIDTH-1:LINE_SIZE_BITS], {LINE_SIZE_BITS{1'b0}}};
  assign unused_offset_bits = ^cpu_addr[LINE_SIZE_BITS-1:0];

  // base is line-aligned, so OR-ing in the beat offset only touches the line offset bits
  assign beat_addr = base | (ADDR_WIDTH'(beat_cnt) << SZ);
  assign last_beat = (beat_cnt == CW'(BEATS - 1));
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign beat_err  = (m_axi_rlast != last_beat) | (m_axi_rresp != 2'b00);

  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      base           <= '0;
      beat_cnt       <= '0;
      m_axi_araddr   <= '0;
      m_axi_arvalid  <= 1'b0;
      m_axi_rready   <= 1'b0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      mem_wstb       <= '0;
      mem_data_valid <= 1'b0;
      mem_last       <= 1'b0;
      refill_err     <= 1'b0;
    end else begin
      // valid and last are single-cycle pulses; addr/data/strobe hold between beats
      mem_data_valid <= 1'b0;
      mem_last       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss) begin
            base          <= line_base;
            m_axi_araddr  <= line_base;
            m_axi_arvalid <= 1'b1;
            beat_cnt      <= '0;
            state         <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_hs) begin
            mem_addr       <= beat_addr;
            mem_data_in    <= m_axi_rdata;
            mem_wstb       <= '1;
            mem_data_valid <= 1'b1;
            mem_last       <= last_beat;
            beat_cnt       <= beat_cnt + CW'(1);
            if (beat_err) begin
              refill_err <= 1'b1;
            end
            // only the beat count ends the burst; a stray rlast is just flagged
            if (last_beat) begin
              m_axi_rready <= 1'b0;
              state        <= S_WAIT_CLR;
            end
          end
        end
        S_WAIT_CLR: begin
          if (!miss) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_axi.sv
// Randomized refill bench: a beat-level reference model predicts every cache-side beat and the sticky error flag.
module tb_cache_refill_axi;

  localparam int BEATS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        miss;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_wstb;
  logic        mem_data_valid;
  logic        mem_last;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        busy;
  logic        refill_err;

  int   checks = 0;
  int   errors = 0;
  logic exp_err = 1'b0;

  cache_refill_axi dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .miss(miss),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wstb(mem_wstb),
    .mem_data_valid(mem_data_valid), .mem_last(mem_last),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .refill_err(refill_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    miss = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_arready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(refill_err), 64'(0));
    reset = 1'b0;
    exp_err = 1'b0;
  endtask

  // One complete miss. gap_mode: 0 back-to-back, 1 rvalid 1,0,0 pattern, 2 random.
  // resp_beat gets SLVERR, rlast is driven on rlast_beat only, rst_beat aborts with reset.
  task automatic refill(input logic [31:0] addr, input int ar_delay, input int gap_mode,
                        input int resp_beat, input int rlast_beat, input int rst_beat);
    logic [31:0] base;
    logic [31:0] beat_data;
    logic [31:0] last_addr;
    logic        hs;
    int          sent;
    int          cyc;
    base = addr & 32'hFFFF_FF80;
    sent = 0;
    cyc = 0;
    last_addr = 32'h0;
    beat_data = 32'h0;
    cpu_addr = addr;
    miss = 1'b1;
    @(negedge clk);
    chk("ar_valid", 64'(m_axi_arvalid), 64'(1));
    chk("ar_addr", 64'(m_axi_araddr), 64'(base));
    chk("ar_len", 64'(m_axi_arlen), 64'(BEATS - 1));
    chk("ar_size", 64'(m_axi_arsize), 64'(2));
    chk("ar_burst", 64'(m_axi_arburst), 64'(1));
    chk("ar_busy", 64'(busy), 64'(1));
    chk("ar_rready", 64'(m_axi_rready), 64'(0));
    cpu_addr = $urandom;
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      chk("ar_hold_valid", 64'(m_axi_arvalid), 64'(1));
      chk("ar_hold_addr", 64'(m_axi_araddr), 64'(base));
      chk("ar_hold_rready", 64'(m_axi_rready), 64'(0));
    end
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    chk("ar_done_valid", 64'(m_axi_arvalid), 64'(0));
    chk("r_rready_on", 64'(m_axi_rready), 64'(1));

    while (sent < BEATS && cyc < 2000) begin
      if (sent == rst_beat) begin
        reset = 1'b1;
        m_axi_rvalid = 1'b0;
        miss = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_err = 1'b0;
        chk("midrst_arvalid", 64'(m_axi_arvalid), 64'(0));
        chk("midrst_rready", 64'(m_axi_rready), 64'(0));
        chk("midrst_valid", 64'(mem_data_valid), 64'(0));
        chk("midrst_last", 64'(mem_last), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        return;
      end
      case (gap_mode)
        0:       m_axi_rvalid = 1'b1;
        1:       m_axi_rvalid = (cyc % 3 == 0);
        default: m_axi_rvalid = 1'($urandom_range(0, 1));
      endcase
      beat_data = $urandom;
      m_axi_rdata = beat_data;
      m_axi_rresp = (sent == resp_beat) ? 2'b10 : 2'b00;
      m_axi_rlast = (sent == rlast_beat);
      chk("r_rready", 64'(m_axi_rready), 64'(1));
      hs = m_axi_rvalid;
      @(negedge clk);
      m_axi_rvalid = 1'b0;
      cyc++;
      chk("r_no_ar", 64'(m_axi_arvalid), 64'(0));
      chk("r_valid", 64'(mem_data_valid), 64'(hs));
      if (hs) begin
        last_addr = base + 32'(sent * 4);
        chk("beat_addr", 64'(mem_addr), 64'(last_addr));
        chk("beat_data", 64'(mem_data_in), 64'(beat_data));
        chk("beat_wstb", 64'(mem_wstb), 64'(4'hF));
        chk("beat_last", 64'(mem_last), 64'(sent == BEATS - 1));
        if ((sent == resp_beat) || ((sent == rlast_beat) != (sent == BEATS - 1)))
          exp_err = 1'b1;
        sent++;
      end else begin
        chk("gap_last", 64'(mem_last), 64'(0));
        if (sent > 0) chk("gap_addr_hold", 64'(mem_addr), 64'(last_addr));
      end
    end
    if (sent < BEATS) chk("r_timeout", 64'(sent), 64'(BEATS));

    chk("end_err", 64'(refill_err), 64'(exp_err));
    repeat (2) begin
      @(negedge clk);
      chk("wait_busy", 64'(busy), 64'(1));
      chk("wait_rready", 64'(m_axi_rready), 64'(0));
      chk("wait_arvalid", 64'(m_axi_arvalid), 64'(0));
      chk("wait_valid", 64'(mem_data_valid), 64'(0));
    end
    miss = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_err", 64'(refill_err), 64'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    miss = 1'b0;
    cpu_addr = '0;
    m_axi_arready = 1'b0;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("reset_rready", 64'(m_axi_rready), 64'(0));
    chk("reset_valid", 64'(mem_data_valid), 64'(0));
    chk("reset_last", 64'(mem_last), 64'(0));
    chk("reset_wstb", 64'(mem_wstb), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_err", 64'(refill_err), 64'(0));
    chk("reset_arlen", 64'(m_axi_arlen), 64'(BEATS - 1));
    reset = 1'b0;
    @(negedge clk);

    refill(32'h0000_1234, 0, 0, -1, BEATS - 1, -1);
    refill($urandom, 5, 0, -1, BEATS - 1, -1);
    refill($urandom, 0, 1, -1, BEATS - 1, -1);
    refill($urandom, 2, 2, -1, BEATS - 1, -1);
    refill($urandom, 0, 2, 7, BEATS - 1, -1);
    do_reset();
    refill($urandom, 0, 0, -1, 30, -1);
    do_reset();
    refill($urandom, 1, 0, -1, BEATS - 1, 10);
    refill($urandom, 1, 2, -1, BEATS - 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
